// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared constants and types for the DMA data path.
//   DMA_DATA_W          default data word width
//   DMA_FIFO_DEPTH      default FIFO depth (power of two)
//   DMA_FIFO_AF_THRESH  default almost-full threshold (level >= value)
//   DMA_FIFO_AE_THRESH  default almost-empty threshold (level <= value)
//   fifo_op_e           accepted-operation summary for one clock cycle
// -----------------------------------------------------------------------------
package dma_pkg;

   localparam int DMA_DATA_W         = 32;
   localparam int DMA_FIFO_DEPTH     = 16;
   localparam int DMA_FIFO_AF_THRESH = DMA_FIFO_DEPTH - 2;
   localparam int DMA_FIFO_AE_THRESH = 2;

   // What the FIFO actually did this cycle, after full/empty qualification.
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_RD    = 2'b01,
      OP_WR    = 2'b10,
      OP_WR_RD = 2'b11
   } fifo_op_e;

endpackage : dma_pkg

// File: rtl/dma_fifo_ram.sv
// -----------------------------------------------------------------------------
// dma_fifo_ram
// Simple dual-port storage array for dma_param_fifo: synchronous write,
// synchronous (registered) read, plus an optional registered debug read port.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   async active-low reset (output registers only)
//   wr_en     in   write strobe
//   wr_addr   in   write index
//   wr_data   in   write data
//   rd_en     in   read strobe; rd_data loads mem[rd_addr] on the next edge
//   rd_addr   in   read index
//   rd_data   out  registered read data, holds when rd_en is low
//   dbg_addr  in   (DMA_FIFO_DBG_PORT_EN only) physical debug index
//   dbg_data  out  (DMA_FIFO_DBG_PORT_EN only) mem[dbg_addr], one-cycle latency
//
// Build option: define DMA_FIFO_DBG_PORT_EN to add the debug read port.
// -----------------------------------------------------------------------------
module dma_fifo_ram
   import dma_pkg::*;
#(
   parameter  int WIDTH = DMA_DATA_W,
   parameter  int DEPTH = DMA_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
`ifdef DMA_FIFO_DBG_PORT_EN
   ,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
`endif
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   // NOTE: the array has no reset on purpose -- resetting it would force it
   // into flops instead of RAM; the pointers guarantee unwritten entries are
   // never read through the FIFO path.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // NOTE: the default assignment first keeps every path assigned, so no
   // latch is inferred when rd_en is low.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

`ifdef DMA_FIFO_DBG_PORT_EN
   logic [WIDTH-1:0] dbg_data_q, dbg_data_d;

   // Free-running observation of a physical entry; never touches FIFO state.
   always_comb begin
      dbg_data_d = mem[dbg_addr];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dbg_data_q <= '0;
      end else begin
         dbg_data_q <= dbg_data_d;
      end
   end

   assign dbg_data = dbg_data_q;
`endif

endmodule : dma_fifo_ram

// File: rtl/dma_param_fifo.sv
// -----------------------------------------------------------------------------
// dma_param_fifo
// Parametrised synchronous FIFO between the DMA read and write engines.
// Pointer, level, flag and sticky-error logic live here; storage lives in
// dma_fifo_ram.
//
// Parameters: WIDTH, DEPTH (power of two, >=4), AF_THRESH (1..DEPTH),
//             AE_THRESH (0..DEPTH-1).
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   async active-low reset
//   wr_en/wr_data in   write request and data (ignored while full)
//   rd_en         in   read request (ignored while empty)
//   rd_data       out  registered read data, one cycle after accepted rd_en
//   rd_valid      out  one-cycle pulse when rd_data was updated
//   full/empty    out  level == DEPTH / level == 0
//   almost_full   out  level >= AF_THRESH
//   almost_empty  out  level <= AE_THRESH
//   level         out  occupancy 0..DEPTH
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
//   err_clr       in   synchronous clear of overflow/underflow (set wins)
//   dbg_addr      in   (DMA_FIFO_DBG_PORT_EN only) physical debug index
//   dbg_data      out  (DMA_FIFO_DBG_PORT_EN only) registered mem[dbg_addr]
//
// Build option: define DMA_FIFO_DBG_PORT_EN to add the debug read port.
// -----------------------------------------------------------------------------
module dma_param_fifo
   import dma_pkg::*;
#(
   parameter  int WIDTH     = DMA_DATA_W,
   parameter  int DEPTH     = DMA_FIFO_DEPTH,
   parameter  int AF_THRESH = DEPTH - 2,
   parameter  int AE_THRESH = DMA_FIFO_AE_THRESH,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [AW:0]      level,
   output logic             overflow,
   output logic             underflow,
   input  logic             err_clr
`ifdef DMA_FIFO_DBG_PORT_EN
   ,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
`endif
);

   localparam int          LW      = AW + 1;
   localparam logic [AW:0] LVL_MAX = LW'(DEPTH);
   localparam logic [AW:0] LVL_AF  = LW'(AF_THRESH);
   localparam logic [AW:0] LVL_AE  = LW'(AE_THRESH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          rd_valid_q, rd_valid_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          full_w, empty_w;
   logic          wr_acc, rd_acc;
   fifo_op_e      op;

   // Flags decode only the level register, so outputs never see inputs
   // combinationally and all flags move together one cycle after the edge.
   assign full_w  = (level_q == LVL_MAX);
   assign empty_w = (level_q == '0);

   // Acceptance is judged on registered state: a full FIFO rejects the
   // write even if a read frees a slot in the same cycle (no write-through),
   // and an empty FIFO rejects the read even if a write arrives (no bypass).
   assign wr_acc = wr_en & ~full_w;
   assign rd_acc = rd_en & ~empty_w;
   assign op     = fifo_op_e'({wr_acc, rd_acc});

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      rd_valid_d  = rd_acc;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      // Pointers wrap DEPTH-1 -> 0 through natural AW-bit rollover.
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case (op)
         OP_WR:   level_d = level_q + LW'(1);
         OP_RD:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Clear first so a same-cycle set takes priority.
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en && full_w) begin
         overflow_d = 1'b1;
      end
      if (rd_en && empty_w) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   dma_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_acc),
      .wr_addr  (wr_ptr_q),
      .wr_data  (wr_data),
      .rd_en    (rd_acc),
      .rd_addr  (rd_ptr_q),
      .rd_data  (rd_data)
`ifdef DMA_FIFO_DBG_PORT_EN
      ,
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
`endif
   );

   assign rd_valid     = rd_valid_q;
   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (level_q >= LVL_AF);
   assign almost_empty = (level_q <= LVL_AE);
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule : dma_param_fifo
